// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the shared-memory bus arbiter.
// Timeout logic is compiled in with MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit
// at or after rr_ptr, wrapping modulo N.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW:0] j;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, rr_ptr} + (IW+1)'(k);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      if (!found && req[j[IW-1:0]]) begin
        found            = 1'b1;
        gnt[j[IW-1:0]]   = 1'b1;
        idx              = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of NUM_MASTERS channels onto one memory bus.
// Define MEM_ARB_TIMEOUT_EN to abandon slave waits after TIMEOUT_CYC.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  output logic [NUM_MASTERS-1:0]        stall,
  output logic                          s_valid,
  output logic                          s_write,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_rdata
);

  localparam int IW = idx_w(NUM_MASTERS);

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic                   s_valid_q, s_valid_d;
  logic                   s_write_q, s_write_d;
  logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
  logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
  logic [NUM_MASTERS-1:0] m_done_q, m_done_d;
  logic [DATA_W-1:0]      m_rdata_q, m_rdata_d;
  logic                   fin;

  logic [NUM_MASTERS-1:0] win_gnt;
  logic [IW-1:0]          win_idx;
  logic [ADDR_W-1:0]      addr_a [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_a [NUM_MASTERS];

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       m_err_q, m_err_d;
`else
  logic       unused_to;
  assign unused_to = ^8'(TIMEOUT_CYC);
`endif

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_slice
    assign addr_a[g]  = m_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = m_wdata[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req    (m_req),
    .rr_ptr (rr_ptr_q),
    .gnt    (win_gnt),
    .idx    (win_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    s_valid_d = s_valid_q;
    s_write_d = s_write_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_rdata_d = m_rdata_q;
    m_done_d  = '0;
    fin       = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    m_err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|win_gnt) begin
          owner_d   = win_idx;
          s_write_d = m_write[win_idx];
          s_addr_d  = addr_a[win_idx];
          s_wdata_d = wdata_a[win_idx];
          s_valid_d = 1'b1;
          state_d   = ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (s_ready) begin
          fin = 1'b1;
          if (!s_write_q) m_rdata_d = s_rdata;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          fin     = 1'b1;
          m_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
        // Completion and timeout share the same hand-back path
        if (fin) begin
          m_done_d[owner_q] = 1'b1;
          s_valid_d         = 1'b0;
          state_d           = ST_IDLE;
          rr_ptr_d = (owner_q == IW'(NUM_MASTERS - 1)) ?
                     '0 : owner_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      s_valid_q <= 1'b0;
      s_write_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_done_q  <= '0;
      m_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      m_err_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      s_valid_q <= s_valid_d;
      s_write_q <= s_write_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_done_q  <= m_done_d;
      m_rdata_q <= m_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      m_err_q   <= m_err_d;
`endif
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  assign m_err = m_err_q;
`else
  assign m_err = 1'b0;
`endif

  assign m_done  = m_done_q;
  assign m_rdata = m_rdata_q;
  assign stall   = m_req & ~m_done_q;
  assign s_valid = s_valid_q;
  assign s_write = s_write_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table on a 2-master
// instance plus hand sequences for reset, timeout and 3 masters.
module tb_mem_arbiter;

  logic         clk;
  logic         rst_n;

  logic [1:0]   m_req, m_write, m_done, stall;
  logic [127:0] m_addr, m_wdata;
  logic [63:0]  m_rdata, s_addr, s_wdata, s_rdata;
  logic         m_err, s_valid, s_write, s_ready;

  logic [2:0]   p_req, p_write, p_done, p_stall;
  logic [47:0]  p_addr, p_wdata;
  logic [15:0]  p_rdata, p_saddr, p_swdata, p_srdata;
  logic         p_err, p_sv, p_sw, p_rdy;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(
    .NUM_MASTERS (2),
    .TIMEOUT_CYC (4)
  ) dut (
    .CLK     (clk),
    .RESET   (rst_n),
    .m_req   (m_req),
    .m_write (m_write),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_done  (m_done),
    .m_rdata (m_rdata),
    .m_err   (m_err),
    .stall   (stall),
    .s_valid (s_valid),
    .s_write (s_write),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_ready (s_ready),
    .s_rdata (s_rdata)
  );

  mem_arbiter #(
    .NUM_MASTERS (3),
    .ADDR_W      (16),
    .DATA_W      (16)
  ) dut3 (
    .CLK     (clk),
    .RESET   (rst_n),
    .m_req   (p_req),
    .m_write (p_write),
    .m_addr  (p_addr),
    .m_wdata (p_wdata),
    .m_done  (p_done),
    .m_rdata (p_rdata),
    .m_err   (p_err),
    .stall   (p_stall),
    .s_valid (p_sv),
    .s_write (p_sw),
    .s_addr  (p_saddr),
    .s_wdata (p_swdata),
    .s_ready (p_rdy),
    .s_rdata (p_srdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic        rdy;
    logic [63:0] rdata;
    logic        sv;
    logic        sw;
    logic [63:0] addr;
    logic [1:0]  done;
    logic [63:0] mrd;
    logic [1:0]  stl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [1:0] req, input logic [1:0] wr,
    input logic rdy, input logic [63:0] rdata,
    input logic sv, input logic sw, input logic [63:0] addr,
    input logic [1:0] done, input logic [63:0] mrd,
    input logic [1:0] stl);
    vec_t v;
    v.req = req; v.wr = wr; v.rdy = rdy; v.rdata = rdata;
    v.sv = sv; v.sw = sw; v.addr = addr;
    v.done = done; v.mrd = mrd; v.stl = stl;
    return v;
  endfunction

  task automatic check(input string nm,
                       input logic [191:0] act,
                       input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n_wait;
    bit  seen;
    bit  err;

    rst_n   = 1'b0;
    m_req   = '0;
    m_write = '0;
    m_addr  = {64'h200, 64'h100};
    m_wdata = {64'hB1, 64'hA0};
    s_ready = 1'b0;
    s_rdata = '0;
    p_req   = '0;
    p_write = 3'b010;
    p_addr  = {16'h30, 16'h20, 16'h10};
    p_wdata = {16'h0, 16'h55, 16'h0};
    p_rdy   = 1'b0;
    p_srdata = '0;

    // req wr rdy rdata | sv sw addr done m_rdata stall
    vq.push_back(mk(2'b00,2'b00,0,64'h0,        0,0,64'h0,  2'b00,64'h0,        2'b00));
    vq.push_back(mk(2'b01,2'b00,0,64'h0,        0,0,64'h0,  2'b00,64'h0,        2'b01));
    vq.push_back(mk(2'b01,2'b00,0,64'h0,        1,0,64'h100,2'b00,64'h0,        2'b01));
    vq.push_back(mk(2'b01,2'b00,0,64'h0,        1,0,64'h100,2'b00,64'h0,        2'b01));
    vq.push_back(mk(2'b01,2'b00,0,64'h0,        1,0,64'h100,2'b00,64'h0,        2'b01));
    vq.push_back(mk(2'b01,2'b00,1,64'hDEADBEEF, 1,0,64'h100,2'b00,64'h0,        2'b01));
    vq.push_back(mk(2'b01,2'b00,0,64'h0,        0,0,64'h100,2'b01,64'hDEADBEEF, 2'b00));
    vq.push_back(mk(2'b00,2'b00,0,64'h0,        1,0,64'h100,2'b00,64'hDEADBEEF, 2'b00));
    vq.push_back(mk(2'b00,2'b00,1,64'h1111,     1,0,64'h100,2'b00,64'hDEADBEEF, 2'b00));
    vq.push_back(mk(2'b00,2'b00,0,64'h0,        0,0,64'h100,2'b01,64'h1111,     2'b00));
    vq.push_back(mk(2'b11,2'b00,1,64'hA,        0,0,64'h100,2'b00,64'h1111,     2'b11));
    vq.push_back(mk(2'b11,2'b00,1,64'hB,        1,0,64'h200,2'b00,64'h1111,     2'b11));
    vq.push_back(mk(2'b11,2'b00,1,64'hC,        0,0,64'h200,2'b10,64'hB,        2'b01));
    vq.push_back(mk(2'b11,2'b00,1,64'hD,        1,0,64'h100,2'b00,64'hB,        2'b11));
    vq.push_back(mk(2'b11,2'b00,1,64'h0,        0,0,64'h100,2'b01,64'hD,        2'b10));
    vq.push_back(mk(2'b11,2'b00,1,64'hE,        1,0,64'h200,2'b00,64'hD,        2'b11));
    vq.push_back(mk(2'b00,2'b00,0,64'h0,        0,0,64'h200,2'b10,64'hE,        2'b00));
    vq.push_back(mk(2'b10,2'b10,0,64'h0,        0,0,64'h200,2'b00,64'hE,        2'b10));
    vq.push_back(mk(2'b10,2'b10,1,64'hF,        1,1,64'h200,2'b00,64'hE,        2'b10));
    vq.push_back(mk(2'b00,2'b00,0,64'h0,        0,1,64'h200,2'b10,64'hE,        2'b00));

    repeat (2) @(posedge clk);
    #1;
    check("reset_2m", {s_valid, s_write, s_addr, s_wdata,
                       m_done, m_rdata, m_err}, '0);
    check("reset_3m", {p_sv, p_sw, p_saddr, p_swdata,
                       p_done, p_rdata, p_err}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      m_req   = vq[i].req;
      m_write = vq[i].wr;
      s_ready = vq[i].rdy;
      s_rdata = vq[i].rdata;
      #1;
      check($sformatf("vec%0d", i),
            {s_valid, s_write, s_addr, m_done, m_rdata, stall},
            {vq[i].sv, vq[i].sw, vq[i].addr,
             vq[i].done, vq[i].mrd, vq[i].stl});
      @(posedge clk);
      #1;
    end
    m_write = '0;

    // Reset in the middle of a BUSY wait, with rr_ptr at 1
    m_req = 2'b01; s_ready = 1'b0;
    cyc();
    s_ready = 1'b1; s_rdata = 64'h22;
    cyc();
    check("rst_pre_done", {m_done, m_err}, {2'b01, 1'b0});
    m_req = 2'b10; s_ready = 1'b0;
    cyc();
    check("rst_busy", {s_valid, s_addr}, {1'b1, 64'h200});
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {s_valid, s_addr, m_done, m_rdata}, '0);
    m_req = 2'b00;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("rst_nodone%0d", i), {m_done, s_valid}, '0);
    end
    m_req = 2'b11;
    cyc();
    check("rst_rr0", {s_valid, s_addr}, {1'b1, 64'h100});
    s_ready = 1'b1; s_rdata = 64'h33;
    cyc();
    check("rst_done0", {m_done, m_rdata, m_err},
          {2'b01, 64'h33, 1'b0});
    m_req = 2'b00; s_ready = 1'b0;
    cyc();

    // Slave that never answers; master drops req after grant
    m_req = 2'b01;
    cyc();
    m_req = 2'b00;
    n_wait = 0; seen = 1'b0; err = 1'b0;
    for (int i = 0; i < 110 && !seen; i++) begin
      cyc();
      n_wait++;
      if (m_done != 2'b00) begin
        seen = 1'b1;
        err  = m_err;
      end
    end
`ifdef MEM_ARB_TIMEOUT_EN
    check("to_cycles", n_wait, 4);
    check("to_err", {seen, err, m_done}, {1'b1, 1'b1, 2'b01});
    check("to_rdata", m_rdata, 64'h33);
`else
    check("no_timeout", {seen, s_valid, m_err},
          {1'b0, 1'b1, 1'b0});
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
`endif
    m_req = 2'b10;
    cyc();
    s_ready = 1'b1; s_rdata = 64'h77;
    cyc();
    check("post_to", {m_done, m_rdata, m_err},
          {2'b10, 64'h77, 1'b0});
    m_req = 2'b00; s_ready = 1'b0;
    cyc();

    // Three masters: move rr_ptr to 1, then 1 and 2 contend
    p_req = 3'b001;
    cyc();
    p_rdy = 1'b1; p_srdata = 16'h1;
    cyc();
    check("m3_done0", p_done, 3'b001);
    p_req = 3'b110; p_rdy = 1'b0;
    cyc();
    check("m3_grant1", {p_sv, p_sw, p_saddr, p_swdata},
          {1'b1, 1'b1, 16'h20, 16'h55});
    p_rdy = 1'b1;
    cyc();
    check("m3_done1", {p_done, p_stall}, {3'b010, 3'b100});
    p_req = 3'b100; p_rdy = 1'b0;
    cyc();
    check("m3_grant2", {p_sv, p_sw, p_saddr},
          {1'b1, 1'b0, 16'h30});
    p_rdy = 1'b1; p_srdata = 16'h1234;
    cyc();
    check("m3_done2", {p_done, p_rdata}, {3'b100, 16'h1234});
    p_req = 3'b101; p_rdy = 1'b0;
    cyc();
    check("m3_wrap0", {p_sv, p_saddr}, {1'b1, 16'h10});
    p_rdy = 1'b1;
    cyc();
    check("m3_done_w", {p_done, p_err}, {3'b001, 1'b0});
    p_req = 3'b000; p_rdy = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
